radar_azimuth_generator: RTL and testbench
==========================================

Name: radar_azimuth_generator

Overview:
Parametrised successor to the fixed-ratio ARP divider in the radar simulator. Generates the antenna azimuth pulse train: ACP (azimuth change pulse, ACP_PER_REV per revolution) and ARP (azimuth reference pulse, once per revolution, coincident with ACP at azimuth 0). It also exposes the current azimuth count. Rotation period is runtime-programmable and changes glitch-free at revolution boundaries; start/stop is graceful.

Parameters:
ACP_PER_REV, 4096, ACP pulses per revolution; legal range >= 2, need not be a power of two
ROT_PERIOD_W, 32, width of the rotation-period input (clock cycles per revolution)
PULSE_WIDTH_CYC, 100, ARP/ACP high time in IN_CLK cycles; legal range >= 1
REV_CNT_W, 16, width of the revolution counter

Ports:
IN_CLK  input  1  system clock, 100 MHz nominal
IN_RESETN  input  1  asynchronous active-low reset
EN  input  1  level; 1 = rotate, 0 = stop at the end of the current revolution
ROT_PERIOD  input  ROT_PERIOD_W  IN_CLK cycles per revolution; sampled only at start and at each azimuth-0 tick
RADAR_ARP  output  1  azimuth reference pulse
RADAR_ACP  output  1  azimuth change pulse
AZIMUTH  output  $clog2(ACP_PER_REV)  current ACP index, 0..ACP_PER_REV-1
REV_COUNT  output  REV_CNT_W  completed revolutions; wraps modulo 2^REV_CNT_W
BUSY  output  1  state != IDLE
CFG_ERR  output  1  sticky; ROT_PERIOD < ACP_PER_REV seen at a sample point

Behaviour:
- Reset, asynchronous, active-low. On reset: state = IDLE and all outputs = 0. Internal registers also clear: accumulator, period shadow, pulse counters.
- States:
  - IDLE: EN=1 with a valid ROT_PERIOD moves to RUN.
  - RUN: EN=0 moves to STOPPING.
  - STOPPING: EN=1 returns to RUN with no discontinuity; a suppressed azimuth-0 tick moves to IDLE.
- Start (IDLE, EN=1):
  - ROT_PERIOD >= ACP_PER_REV: shadow P := ROT_PERIOD, acc := 0, AZIMUTH := 0, and a tick at az 0 is emitted. Both ARP and ACP go high on the next clock edge (1-cycle latency from EN sampled).
  - ROT_PERIOD < ACP_PER_REV (including 0): stay in IDLE, set CFG_ERR.
- Tick generation in RUN/STOPPING uses a fractional accumulator, width ROT_PERIOD_W+1, with no divider:
  - each cycle, s = acc + ACP_PER_REV;
  - if s >= P, then tick and acc := s - P; otherwise acc := s.
  - The k-th tick after an azimuth-0 tick lands exactly at cycle ceil(k*P/ACP_PER_REV).
  - Exactly ACP_PER_REV ticks per P cycles; the ARP-to-ARP period is exactly P; acc = 0 at every azimuth-0 tick.
- On each tick: AZIMUTH increments, wrapping ACP_PER_REV-1 -> 0. When the wrap to 0 occurs:
  - ARP fires;
  - REV_COUNT increments;
  - shadow P reloads from ROT_PERIOD. If the new value is < ACP_PER_REV, CFG_ERR is set, the old P is kept, and RUN continues.
- Pulse shaping:
  - Each tick (re)loads the ACP width counter with PULSE_WIDTH_CYC; the output is high while the counter is non-zero.
  - The ARP counter works the same way but is loaded only on azimuth-0 ticks.
  - A retrigger while high extends the pulse: pulses merge if P/ACP_PER_REV <= PULSE_WIDTH_CYC. This is legal, not an error.
- STOPPING: ticks continue normally. The tick that would wrap to azimuth 0 is suppressed: no ACP, no ARP, no REV_COUNT increment. Then state = IDLE and AZIMUTH := 0. Pulses already in flight complete their full width.
- ROT_PERIOD changes mid-revolution have no effect until the next azimuth-0 tick.
- CFG_ERR clears only on reset.

Decomposition:
- Package radar_sim_pkg:
  - state enum (IDLE, RUN, STOPPING);
  - default CLK_FREQ_HZ = 100000000;
  - derived AZ_W = $clog2(ACP_PER_REV) helper;
  - nominal constant ROT_PERIOD_12S = 1200000000.
- Sub-module pulse_stretcher, parameter WIDTH_CYC, ports IN_CLK/IN_RESETN/TRIG/OUT, retriggerable. Instantiated twice, for ACP and ARP.

Test Plan:
1. ACP_PER_REV=4, PULSE_WIDTH_CYC=1, ROT_PERIOD=16, EN=1 -> ARP+ACP high 1 cycle after EN. ACP every 4 cycles, ARP every 16. AZIMUTH 0,1,2,3,0. REV_COUNT increments every 16 cycles.
2. ACP_PER_REV=4, ROT_PERIOD=10 -> ticks at offsets 0,3,5,8,10 from start (ceil rule). ARP period exactly 10 over 5 revolutions.
3. ROT_PERIOD 16 -> 20 written mid-revolution -> current revolution still 16 cycles, next ARP-to-ARP interval 20, no extra or missing ACP.
4. EN dropped at AZIMUTH=1 -> ACPs for az 2,3 still emitted, no ARP/ACP at wrap, BUSY low and AZIMUTH=0 in the cycle after the suppressed tick. EN re-raised at az 2 instead -> uninterrupted rotation.
5. EN=1 with ROT_PERIOD=3 (< ACP_PER_REV=4) -> stays IDLE, CFG_ERR=1 and sticky. Later ROT_PERIOD=16 -> starts normally, CFG_ERR remains 1.
6. IN_RESETN asserted mid-pulse in RUN -> all outputs 0 asynchronously. After release with EN=1 -> restart from azimuth 0 with fresh ARP. PULSE_WIDTH_CYC=6 with P/N=4 -> ACP stays continuously high (retrigger merge).

Source files
------------

// File: rtl/radar_sim_pkg.sv
// radar_sim_pkg: shared types and constants for the radar simulator azimuth blocks
package radar_sim_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    localparam int CLK_FREQ_HZ    = 100000000;
    localparam int ROT_PERIOD_12S = 1200000000;

    function automatic int az_w(input int acp_per_rev);
        return $clog2(acp_per_rev);
    endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: retriggerable one-shot; OUT stays high WIDTH_CYC cycles after the last TRIG
// Ports: IN_CLK clock, IN_RESETN async active-low reset, TRIG load pulse, OUT stretched level
module pulse_stretcher #(
    parameter int WIDTH_CYC = 100
) (
    input  logic IN_CLK,
    input  logic IN_RESETN,
    input  logic TRIG,
    output logic OUT
);

    localparam int CW = $clog2(WIDTH_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge IN_CLK or negedge IN_RESETN) begin
        if (!IN_RESETN)
            cnt <= '0;
        else
            cnt <= TRIG ? CW'(WIDTH_CYC) : (cnt != '0 ? cnt - CW'(1) : cnt);
    end

    assign OUT = cnt != '0;

endmodule

// File: rtl/radar_azimuth_generator.sv
// radar_azimuth_generator: programmable-period ACP/ARP azimuth pulse generator
// Ports: IN_CLK/IN_RESETN clock and async active-low reset; EN rotate level;
//        ROT_PERIOD cycles per revolution; RADAR_ARP/RADAR_ACP pulses; AZIMUTH index;
//        REV_COUNT completed revolutions; BUSY not idle; CFG_ERR sticky bad-period flag
module radar_azimuth_generator
    import radar_sim_pkg::*;
#(
    parameter int ACP_PER_REV     = 4096,
    parameter int ROT_PERIOD_W    = 32,
    parameter int PULSE_WIDTH_CYC = 100,
    parameter int REV_CNT_W       = 16
) (
    input  logic                             IN_CLK,
    input  logic                             IN_RESETN,
    input  logic                             EN,
    input  logic [ROT_PERIOD_W-1:0]          ROT_PERIOD,
    output logic                             RADAR_ARP,
    output logic                             RADAR_ACP,
    output logic [az_w(ACP_PER_REV)-1:0]     AZIMUTH,
    output logic [REV_CNT_W-1:0]             REV_COUNT,
    output logic                             BUSY,
    output logic                             CFG_ERR
);

    localparam int              AW      = ROT_PERIOD_W + 1;
    localparam int              AZ_W    = az_w(ACP_PER_REV);
    localparam logic [AW-1:0]   N_EXT   = AW'(ACP_PER_REV);
    localparam logic [AZ_W-1:0] AZ_LAST = AZ_W'(ACP_PER_REV - 1);

    state_t                  state, state_nx;
    logic [AW-1:0]           acc, acc_nx, sum;
    logic [ROT_PERIOD_W-1:0] period, period_nx;
    logic [AZ_W-1:0]         az_nx;
    logic [REV_CNT_W-1:0]    rev_nx;
    logic                    cfg_err_nx, rot_ok, tick, wrap, suppress, acp_trig, arp_trig;

    // Fractional accumulator: one extra bit so acc + ACP_PER_REV never overflows
    assign sum      = acc + N_EXT;
    assign rot_ok   = {1'b0, ROT_PERIOD} >= N_EXT;
    assign tick     = (state != IDLE) && (sum >= {1'b0, period});
    assign wrap     = tick && (AZIMUTH == AZ_LAST);
    // EN back high in STOPPING cancels the stop, so the wrap tick is then emitted normally
    assign suppress = wrap && (state == STOPPING) && !EN;
    assign BUSY     = state != IDLE;

    always_comb begin
        state_nx   = state;
        acc_nx     = acc;
        period_nx  = period;
        az_nx      = AZIMUTH;
        rev_nx     = REV_COUNT;
        cfg_err_nx = CFG_ERR;
        acp_trig   = 1'b0;
        arp_trig   = 1'b0;
        if (state == IDLE) begin
            if (EN && rot_ok) begin
                state_nx  = RUN;
                acc_nx    = '0;
                period_nx = ROT_PERIOD;
                az_nx     = '0;
                acp_trig  = 1'b1;
                arp_trig  = 1'b1;
            end else if (EN) begin
                cfg_err_nx = 1'b1;
            end
        end else begin
            state_nx = EN ? RUN : STOPPING;
            acc_nx   = tick ? sum - {1'b0, period} : sum;
            if (suppress) begin
                state_nx = IDLE;
                acc_nx   = '0;
                az_nx    = '0;
            end else if (tick) begin
                acp_trig = 1'b1;
                az_nx    = wrap ? '0 : AZIMUTH + AZ_W'(1);
                if (wrap) begin
                    arp_trig = 1'b1;
                    rev_nx   = REV_COUNT + REV_CNT_W'(1);
                    // A bad new period keeps the old one so rotation never stalls
                    if (rot_ok)
                        period_nx = ROT_PERIOD;
                    else
                        cfg_err_nx = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge IN_CLK or negedge IN_RESETN) begin
        if (!IN_RESETN) begin
            state     <= IDLE;
            acc       <= '0;
            period    <= '0;
            AZIMUTH   <= '0;
            REV_COUNT <= '0;
            CFG_ERR   <= 1'b0;
        end else begin
            state     <= state_nx;
            acc       <= acc_nx;
            period    <= period_nx;
            AZIMUTH   <= az_nx;
            REV_COUNT <= rev_nx;
            CFG_ERR   <= cfg_err_nx;
        end
    end

    pulse_stretcher #(.WIDTH_CYC(PULSE_WIDTH_CYC)) u_acp (
        .IN_CLK    (IN_CLK),
        .IN_RESETN (IN_RESETN),
        .TRIG      (acp_trig),
        .OUT       (RADAR_ACP)
    );

    pulse_stretcher #(.WIDTH_CYC(PULSE_WIDTH_CYC)) u_arp (
        .IN_CLK    (IN_CLK),
        .IN_RESETN (IN_RESETN),
        .TRIG      (arp_trig),
        .OUT       (RADAR_ARP)
    );

endmodule

// File: tb/tb_radar_azimuth_generator.sv
// tb_radar_azimuth_generator: directed tables, corner sequences and a timestamp-based reference model
module tb_radar_azimuth_generator;

    localparam int N  = 4;
    localparam int RW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [RW-1:0] rot = '0;

    logic          arp1, acp1, busy1, err1, arp6, acp6, busy6, err6;
    logic [1:0]    az1, az6;
    logic [15:0]   rev1, rev6;

    int n_chk = 0;
    int n_err = 0;
    bit mchk  = 1'b0;

    always #5 clk = ~clk;

    radar_azimuth_generator #(.ACP_PER_REV(N), .ROT_PERIOD_W(RW), .PULSE_WIDTH_CYC(1), .REV_CNT_W(16)) u1 (
        .IN_CLK(clk), .IN_RESETN(rst_n), .EN(en), .ROT_PERIOD(rot),
        .RADAR_ARP(arp1), .RADAR_ACP(acp1), .AZIMUTH(az1), .REV_COUNT(rev1),
        .BUSY(busy1), .CFG_ERR(err1)
    );

    radar_azimuth_generator #(.ACP_PER_REV(N), .ROT_PERIOD_W(RW), .PULSE_WIDTH_CYC(6), .REV_CNT_W(16)) u6 (
        .IN_CLK(clk), .IN_RESETN(rst_n), .EN(en), .ROT_PERIOD(rot),
        .RADAR_ARP(arp6), .RADAR_ACP(acp6), .AZIMUTH(az6), .REV_COUNT(rev6),
        .BUSY(busy6), .CFG_ERR(err6)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position within a revolution is c cycles after the az-0 tick;
    // ticks completed = floor(c*N/P); pulses are high while (now - last trigger) < width.
    bit     m_act, m_stop, m_err;
    longint m_c, m_p, m_az, m_rev, m_cyc, m_lacp, m_larp, k;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_act = 0; m_stop = 0; m_err = 0; m_c = 0; m_p = 0; m_az = 0; m_rev = 0;
            m_cyc = 0; m_lacp = -100; m_larp = -100;
        end else begin
            m_cyc++;
            if (!m_act) begin
                if (en && rot >= N) begin
                    m_act = 1; m_stop = 0; m_p = rot; m_c = 0; m_az = 0;
                    m_lacp = m_cyc; m_larp = m_cyc;
                end else if (en) m_err = 1;
            end else begin
                m_c++;
                k = m_c * N / m_p;
                if (k != (m_c - 1) * N / m_p) begin
                    if (k == N) begin
                        if (m_stop && !en) begin
                            m_act = 0; m_az = 0;
                        end else begin
                            m_lacp = m_cyc; m_larp = m_cyc; m_rev++; m_c = 0; m_az = 0;
                            if (rot >= N) m_p = rot; else m_err = 1;
                        end
                    end else begin
                        m_az = k; m_lacp = m_cyc;
                    end
                end
                m_stop = !en;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (mchk) begin
            chk("m_az",   az1,   m_az);
            chk("m_rev",  rev1,  m_rev % 65536);
            chk("m_busy", busy1, m_act);
            chk("m_err",  err1,  m_err);
            chk("m_acp",  acp1,  (m_cyc - m_lacp) < 1);
            chk("m_arp",  arp1,  (m_cyc - m_larp) < 1);
            chk("m_acp6", acp6,  (m_cyc - m_lacp) < 6);
            chk("m_arp6", arp6,  (m_cyc - m_larp) < 6);
            chk("m_az6",  az6,   m_az);
            chk("m_rev6", rev6,  m_rev % 65536);
            chk("m_busy6", busy6, m_act);
            chk("m_err6", err6,  m_err);
        end
    end

    // Counts cycles until the next ARP, plus ACP cycles (PW=1) and merged-ACP gaps (PW=6)
    task automatic measure_rev(output int len, output int acps, output int lows6);
        len = 0; acps = 0; lows6 = 0;
        do begin
            @(negedge clk);
            len++;
            if (acp1) acps++;
            if (!acp6) lows6++;
        end while (!arp1 && len < 200);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, busy1, 0);
    endtask

    typedef struct {
        logic          en;
        logic [RW-1:0] rot;
        logic          acp;
        logic          arp;
        logic [1:0]    az;
        logic [15:0]   rev;
        logic          busy;
    } vec_t;

    vec_t tbl[14];
    int   len, acps, lows6, guard;
    logic [15:0] r0;

    initial begin
        // P=10, N=4: ticks at 0,3,5,8,10 cycles after start
        tbl[0]  = '{1'b1, 16'd10, 1'b1, 1'b1, 2'd0, 16'd0, 1'b1};
        tbl[1]  = '{1'b1, 16'd10, 1'b0, 1'b0, 2'd0, 16'd0, 1'b1};
        tbl[2]  = '{1'b1, 16'd10, 1'b0, 1'b0, 2'd0, 16'd0, 1'b1};
        tbl[3]  = '{1'b1, 16'd10, 1'b1, 1'b0, 2'd1, 16'd0, 1'b1};
        tbl[4]  = '{1'b1, 16'd10, 1'b0, 1'b0, 2'd1, 16'd0, 1'b1};
        tbl[5]  = '{1'b1, 16'd10, 1'b1, 1'b0, 2'd2, 16'd0, 1'b1};
        tbl[6]  = '{1'b1, 16'd10, 1'b0, 1'b0, 2'd2, 16'd0, 1'b1};
        tbl[7]  = '{1'b1, 16'd10, 1'b0, 1'b0, 2'd2, 16'd0, 1'b1};
        tbl[8]  = '{1'b1, 16'd10, 1'b1, 1'b0, 2'd3, 16'd0, 1'b1};
        tbl[9]  = '{1'b1, 16'd10, 1'b0, 1'b0, 2'd3, 16'd0, 1'b1};
        tbl[10] = '{1'b1, 16'd10, 1'b1, 1'b1, 2'd0, 16'd1, 1'b1};
        tbl[11] = '{1'b1, 16'd10, 1'b0, 1'b0, 2'd0, 16'd1, 1'b1};
        tbl[12] = '{1'b1, 16'd10, 1'b0, 1'b0, 2'd0, 16'd1, 1'b1};
        tbl[13] = '{1'b1, 16'd10, 1'b1, 1'b0, 2'd1, 16'd1, 1'b1};

        mchk = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_arp", arp1, 0);
        chk("rst_acp", acp1, 0);
        chk("rst_az", az1, 0);
        chk("rst_rev", rev1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_err", err1, 0);
        rst_n = 1'b1;

        // Ceil-rule tick placement
        for (int i = 0; i < 14; i++) begin
            en  = tbl[i].en;
            rot = tbl[i].rot;
            @(negedge clk);
            chk($sformatf("tbl%0d_acp", i), acp1, tbl[i].acp);
            chk($sformatf("tbl%0d_arp", i), arp1, tbl[i].arp);
            chk($sformatf("tbl%0d_az", i), az1, tbl[i].az);
            chk($sformatf("tbl%0d_rev", i), rev1, tbl[i].rev);
            chk($sformatf("tbl%0d_busy", i), busy1, tbl[i].busy);
        end
        guard = 0;
        while (!arp1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("t2_arp_seen", arp1, 1);
        for (int i = 0; i < 5; i++) begin
            measure_rev(len, acps, lows6);
            chk($sformatf("t2_rev%0d_len", i), len, 10);
            chk($sformatf("t2_rev%0d_acps", i), acps, 4);
        end
        en = 1'b0;
        wait_idle("t2_stop");

        // Period change mid-revolution takes effect at the next azimuth 0
        en = 1'b1; rot = 16'd16;
        @(negedge clk);
        chk("t3_start_arp", arp1, 1);
        chk("t3_start_acp", acp1, 1);
        repeat (5) @(negedge clk);
        rot = 16'd20;
        measure_rev(len, acps, lows6);
        chk("t3_rest_len", len, 11);
        chk("t3_rest_acps", acps, 3);
        chk("t3_merge16", lows6, 0);
        measure_rev(len, acps, lows6);
        chk("t3_next_len", len, 20);
        chk("t3_next_acps", acps, 4);
        chk("t3_merge20", lows6, 0);
        en = 1'b0;
        wait_idle("t3_stop");

        // Graceful stop dropped at azimuth 1
        en = 1'b1; rot = 16'd16;
        @(negedge clk);
        chk("t4_start_arp", arp1, 1);
        r0 = rev1;
        repeat (4) @(negedge clk);
        chk("t4_az1", az1, 1);
        en = 1'b0;
        repeat (4) @(negedge clk);
        chk("t4_acp_az2", acp1, 1);
        chk("t4_az2", az1, 2);
        repeat (4) @(negedge clk);
        chk("t4_acp_az3", acp1, 1);
        chk("t4_az3", az1, 3);
        repeat (3) @(negedge clk);
        chk("t4_busy_pre", busy1, 1);
        @(negedge clk);
        chk("t4_sup_acp", acp1, 0);
        chk("t4_sup_arp", arp1, 0);
        chk("t4_sup_busy", busy1, 0);
        chk("t4_sup_az", az1, 0);
        chk("t4_sup_rev", rev1, r0);

        // Stop cancelled at azimuth 2
        en = 1'b1;
        @(negedge clk);
        r0 = rev1;
        repeat (4) @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        chk("t4b_az2", az1, 2);
        en = 1'b1;
        repeat (8) @(negedge clk);
        chk("t4b_acp", acp1, 1);
        chk("t4b_arp", arp1, 1);
        chk("t4b_az", az1, 0);
        chk("t4b_rev", rev1, 16'(r0 + 16'd1));
        chk("t4b_busy", busy1, 1);
        en = 1'b0;
        wait_idle("t4b_stop");

        // Illegal period at start
        rot = 16'd3; en = 1'b1;
        @(negedge clk);
        chk("t5_busy", busy1, 0);
        chk("t5_err", err1, 1);
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_sticky", err1, 1);
        rot = 16'd0; en = 1'b1;
        @(negedge clk);
        chk("t5_zero_busy", busy1, 0);
        rot = 16'd16;
        @(negedge clk);
        chk("t5_ok_busy", busy1, 1);
        chk("t5_ok_arp", arp1, 1);
        chk("t5_ok_err", err1, 1);

        // Asynchronous reset mid-pulse, then restart
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_arp", arp1, 0);
        chk("t6_acp", acp1, 0);
        chk("t6_az", az1, 0);
        chk("t6_rev", rev1, 0);
        chk("t6_busy", busy1, 0);
        chk("t6_err", err1, 0);
        chk("t6_arp6", arp6, 0);
        chk("t6_acp6", acp6, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_re_arp", arp1, 1);
        chk("t6_re_acp", acp1, 1);
        chk("t6_re_az", az1, 0);
        chk("t6_re_busy", busy1, 1);

        // Random EN/ROT_PERIOD traffic against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 3) en = ~en;
            if ($urandom_range(0, 99) < 5)
                rot = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom_range(4, 40));
        end
        @(negedge clk);
        mchk = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
